// File: rtl/enemy_missile_pool_if.sv
// Bus bundle between the alien formation / draw-collision logic and the enemy missile pool.
// Latency: none, wires only.
// Backpressure: none; fire requests are pulses answered by fire_ack / fire_drop.
interface enemy_missile_pool_if #(
  parameter int NUM_MISSILES = 4,
  parameter int PIXEL_WIDTH  = 11
);
  logic                                  startOfFrame;
  logic                                  fire_request;
  logic [PIXEL_WIDTH-1:0]                shooter_X;
  logic [PIXEL_WIDTH-1:0]                shooter_Y;
  logic [NUM_MISSILES-1:0]               collision;
  logic [NUM_MISSILES*PIXEL_WIDTH-1:0]   missiles_X;
  logic [NUM_MISSILES*PIXEL_WIDTH-1:0]   missiles_Y;
  logic [NUM_MISSILES-1:0]               missile_active;
  logic                                  fire_ack;
  logic                                  fire_drop;

  // Formation / collision side: drives requests and collisions, observes the pool.
  modport master (
    output startOfFrame, fire_request, shooter_X, shooter_Y, collision,
    input  missiles_X, missiles_Y, missile_active, fire_ack, fire_drop
  );

  // Missile pool side.
  modport slave (
    input  startOfFrame, fire_request, shooter_X, shooter_Y, collision,
    output missiles_X, missiles_Y, missile_active, fire_ack, fire_drop
  );
endinterface

// File: rtl/enemy_missile_pool.sv
// Pool of downward enemy missiles: spawn on request, move per frame, retire on hit or bottom exit.
// Latency: spawn/move/retire visible one cycle after startOfFrame; collision clears one cycle later.
// Backpressure: none; a blocked request (cooldown or pool full) is dropped with a fire_drop pulse.
module enemy_missile_pool #(
  parameter int NUM_MISSILES    = 4,
  parameter int PIXEL_WIDTH     = 11,
  parameter int Y_SPEED         = 128,
  parameter int X_OFFSET        = 15,
  parameter int Y_OFFSET        = 32,
  parameter int SCREEN_BOTTOM   = 480,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  enemy_missile_pool_if.slave   bus
);

  // Y is kept in 1/64 px fixed point so sub-pixel speeds accumulate.
  localparam int FW     = PIXEL_WIDTH + 6;
  localparam int CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int SLOT_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;

  localparam logic [PIXEL_WIDTH-1:0]        X_OFF     = PIXEL_WIDTH'(X_OFFSET);
  localparam logic [PIXEL_WIDTH-1:0]        Y_OFF     = PIXEL_WIDTH'(Y_OFFSET);
  localparam logic signed [PIXEL_WIDTH-1:0] BOTTOM_PX = PIXEL_WIDTH'(SCREEN_BOTTOM);
  localparam logic signed [FW-1:0]          SPEED_FX  = FW'(Y_SPEED);
  localparam logic [CD_W-1:0]               CD_LOAD   = CD_W'(COOLDOWN_FRAMES);

  logic                    pending_q;
  logic [CD_W-1:0]         cooldown_q;
  logic                    ack_q;
  logic                    drop_q;
  logic [NUM_MISSILES-1:0] active_vec;

  logic                    spawn_hit;
  logic [SLOT_W-1:0]       spawn_idx;
  logic                    do_spawn;
  logic                    do_drop;
  logic [PIXEL_WIDTH-1:0]  spawn_x;
  logic [PIXEL_WIDTH-1:0]  spawn_y_px;
  logic signed [FW-1:0]    spawn_y_fx;

  // Lowest-index free slot; a slot being hit this cycle is not free until next frame.
  always_comb begin
    spawn_hit = 1'b0;
    spawn_idx = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      if (!active_vec[i] && !bus.collision[i]) begin
        spawn_hit = 1'b1;
        spawn_idx = SLOT_W'(i);
      end
    end
  end

  assign do_spawn   = bus.startOfFrame && pending_q && (cooldown_q == '0) && spawn_hit;
  assign do_drop    = bus.startOfFrame && pending_q && !do_spawn;
  assign spawn_x    = bus.shooter_X + X_OFF;
  assign spawn_y_px = bus.shooter_Y + Y_OFF;
  assign spawn_y_fx = {spawn_y_px, 6'b000000};

  // Request bookkeeping: a request arriving with startOfFrame is kept for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      cooldown_q <= '0;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ack_q  <= do_spawn;
      drop_q <= do_drop;
      if (bus.fire_request) begin
        pending_q <= 1'b1;
      end else if (bus.startOfFrame) begin
        pending_q <= 1'b0;
      end
      if (do_spawn) begin
        cooldown_q <= CD_LOAD;
      end else if (bus.startOfFrame && (cooldown_q != '0)) begin
        cooldown_q <= cooldown_q - CD_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
    logic                          act_q;
    logic signed [PIXEL_WIDTH-1:0] x_q;
    logic signed [FW-1:0]          y_q;
    logic signed [FW-1:0]          mv_y;
    logic signed [PIXEL_WIDTH-1:0] mv_px;
    logic signed [PIXEL_WIDTH-1:0] y_px;

    assign mv_y  = y_q + SPEED_FX;
    assign mv_px = mv_y[FW-1:6];
    assign y_px  = y_q[FW-1:6];

    // Slot state: collision wins over spawn and movement; bottom exit zeroes the slot.
    always_ff @(posedge clk) begin
      if (reset || bus.collision[g]) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (do_spawn && (spawn_idx == SLOT_W'(g))) begin
        act_q <= 1'b1;
        x_q   <= spawn_x;
        y_q   <= spawn_y_fx;
      end else if (bus.startOfFrame && act_q) begin
        if (mv_px >= BOTTOM_PX) begin
          act_q <= 1'b0;
          x_q   <= '0;
          y_q   <= '0;
        end else begin
          y_q <= mv_y;
        end
      end
    end

    assign active_vec[g]                                 = act_q;
    assign bus.missiles_X[g*PIXEL_WIDTH +: PIXEL_WIDTH]  = act_q ? x_q  : '0;
    assign bus.missiles_Y[g*PIXEL_WIDTH +: PIXEL_WIDTH]  = act_q ? y_px : '0;
  end

  assign bus.missile_active = active_vec;
  assign bus.fire_ack       = ack_q;
  assign bus.fire_drop      = drop_q;

endmodule

// File: doc/enemy_missile_pool.md
# enemy_missile_pool

Downward-travelling missile manager for the invader side of the game. It accepts fire requests from the alien formation controller and allocates each one to a free slot in a fixed pool of missiles. Every frame it advances all active missiles downward in 1/64-pixel fixed point, and retires each missile on collision or when it leaves the bottom of the screen. It sits between the alien formation logic and the draw/collision logic, alongside the player missile block, and moves in the opposite direction to it.

## Interface
- NUM_MISSILES, 4: pool size (1..8)
- PIXEL_WIDTH, 11: pixel coordinate width
- Y_SPEED, 128: downward speed in 1/64 px per frame (128 = 2 px/frame), positive
- X_OFFSET, 15: added to shooter_X at spawn (signed, PIXEL_WIDTH)
- Y_OFFSET, 32: added to shooter_Y at spawn (signed, PIXEL_WIDTH)
- SCREEN_BOTTOM, 480: pixel Y at or beyond which a missile is retired
- COOLDOWN_FRAMES, 20: minimum frames between two spawns
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- fire_request  in  1  one-cycle pulse: shooter wants to fire
- shooter_X  in  PIXEL_WIDTH  shooter top-left X, sampled at spawn
- shooter_Y  in  PIXEL_WIDTH  shooter top-left Y, sampled at spawn
- collision  in  NUM_MISSILES  per-slot collision, bit i = slot i
- missiles_X  out  NUM_MISSILES*PIXEL_WIDTH  packed signed top-left X, slot i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
- missiles_Y  out  NUM_MISSILES*PIXEL_WIDTH  packed signed top-left Y, same packing
- missile_active  out  NUM_MISSILES  slot i on screen
- fire_ack  out  1  one-cycle pulse: pending request spawned
- fire_drop  out  1  one-cycle pulse: pending request discarded

## Operation
- Per slot state: active bit, X (pixel, PIXEL_WIDTH signed), Y fixed point (PIXEL_WIDTH+6 bits signed, ×64).
- Global state: pending flag, cooldown counter (width clog2(COOLDOWN_FRAMES+1)).
- Reset: all outputs 0, all slot registers 0, pending 0, cooldown 0.
- fire_request sets pending. A request that arrives while pending is already 1 is merged into it.
- Frame processing, on each startOfFrame cycle:
  - Pending resolution:
    - If pending=1, cooldown=0 and a free slot exists, spawn into the lowest-index free slot. Spawn sets X = shooter_X+X_OFFSET and Y = (shooter_Y+Y_OFFSET)×64, sets active, loads cooldown=COOLDOWN_FRAMES and pulses fire_ack.
    - If pending=1 and spawn is blocked (cooldown≠0 or pool full), pulse fire_drop.
    - pending is cleared in both cases.
  - Cooldown: if nonzero and no spawn occurs this frame, decrement by 1.
  - Movement: every slot that was active before this cycle, is not colliding this cycle and is not the spawn target adds Y_SPEED to Y.
  - Retirement: if the updated pixel Y (fixed >>> 6) is ≥ SCREEN_BOTTOM, clear active and zero the slot.
- Free slot means the registered active bit is 0 **and** its collision bit is 0 this cycle. A slot freed by collision this cycle cannot be reused until the next frame.
- collision[i], on any cycle: clears active[i] and zeros X and Y of slot i. Collision has priority over movement of that slot.
- Simultaneous fire_request and startOfFrame:
  - The existing pending is resolved as above.
  - The new request sets pending afterwards, for the next frame.
- A spawn is never placed into a slot with collision asserted.
- Outputs:
  - missiles_Y = Y fixed point >>> 6, arithmetic shift, truncated to PIXEL_WIDTH.
  - missiles_X = stored X.
  - Inactive slots output 0.
- Arithmetic: spawn sums are PIXEL_WIDTH signed and wrap silently. The bench constrains inputs so that no wrap occurs.

## Timing
- All outputs are registered.
- Spawn becomes visible on the cycle after the startOfFrame edge, i.e. in the frame following the request.
- fire_ack / fire_drop are high for exactly the cycle after the startOfFrame edge.
- Movement and retirement updates are visible on the cycle after startOfFrame.
- Collision clears the slot on the cycle after collision is asserted.
- Reset mid-flight clears every slot, pending and cooldown on the next edge. No pulse is emitted in that cycle.
- startOfFrame is at least 2 cycles apart. Behaviour for back-to-back pulses is not required.

## Test plan
- Single shot: reset, shooter=(100,50), fire_request, then startOfFrame.
  - Required: next cycle slot0 active, X=115, Y=82, fire_ack=1.
  - After 3 more frames: Y=88.
- Cooldown: spawn, then fire_request each frame for 25 frames, COOLDOWN_FRAMES=20.
  - Required: fire_drop on frames 1..20.
  - Required: second spawn (slot1) at frame 21, with one fire_ack.
- Pool full: COOLDOWN_FRAMES=0, 5 requests on consecutive frames.
  - Required: slots 0..3 are filled in order.
  - Required: the 5th request gives fire_drop, and missile_active=4'b1111.
- Collision and reuse: with slots 0,1 active, assert collision=4'b0001.
  - Required: slot0 clears next cycle, slot1 is unaffected.
  - Required: the next request spawns into slot0.
- Same-cycle collision and spawn: pending=1, only slot2 free, collision[2] together with startOfFrame.
  - Required: slot2 inactive, fire_drop=1.
- Bottom exit and reset: spawn at Y=476 with speed 128.
  - Required: after 2 frames Y reaches 480, and the slot retires on that frame.
  - Then assert reset mid-flight. Required: all outputs 0 the next cycle.
